// File: rtl/mem_stream_reader_pkg.sv
// Shared types and sizing for the memory stream reader.
package mem_stream_reader_pkg;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mem_stream_reader_fifo.sv
// Two-entry shift FIFO; entry0 is always the head so the output word is a flop.
import mem_stream_reader_pkg::*;

module mem_stream_reader_fifo #(
    parameter int unsigned DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [DATA_WIDTH-1:0] entry0;
    logic [DATA_WIDTH-1:0] entry1;

    // Push into a full FIFO cannot happen: the reader's credit check forbids it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == FIFO_CNT_W'(0)) entry0 <= din;
                    else                         entry1 <= din;
                    count <= count + FIFO_CNT_W'(1);
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - FIFO_CNT_W'(1);
                end
                2'b11: begin
                    if (count == FIFO_CNT_W'(1)) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = entry0;
    assign valid = (count != FIFO_CNT_W'(0));

endmodule

// File: rtl/mem_stream_reader.sv
// Streams a range of a synchronous-read memory over valid/ready.
// Optional running checksum output: define MEM_STREAM_READER_CHECKSUM_EN.
import mem_stream_reader_pkg::*;

module mem_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_en,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] counter;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  inflight;
    logic                  start_acc;
    logic                  issue;
    logic                  pop;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [2:0]            occupancy;

    assign mem_write_en = 1'b0;

    mem_stream_reader_fifo #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (inflight),
        .din   (mem_data_in),
        .pop   (pop),
        .dout  (out_data),
        .valid (out_valid),
        .count (fifo_count)
    );

    // Words owed to the FIFO after this edge must fit its two slots.
    always_comb begin
        pop       = out_valid && out_ready;
        occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
        issue     = (state_q == RUN) && (remaining != '0) && (occupancy < 3'(FIFO_DEPTH));
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = (length != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (remaining == '0) state_d = DRAIN;
            end
            DRAIN: begin
                if (!inflight && ((fifo_count == FIFO_CNT_W'(0)) ||
                                  (fifo_count == FIFO_CNT_W'(1) && pop)))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            counter   <= '0;
            remaining <= '0;
            mem_addr  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            if (start_acc) begin
                counter   <= base_addr;
                remaining <= length;
            end else if (issue) begin
                mem_addr  <= counter;
                counter   <= counter + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)         checksum <= '0;
        else if (start_acc) checksum <= '0;
        else if (pop)       checksum <= checksum + out_data;
    end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader against a preloaded memory model.
module tb_mem_stream_reader;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [6:0]  length = '0;
    logic        busy;
    logic        done;
    logic [5:0]  mem_addr;
    logic        mem_write_en;
    logic [13:0] mem_data_in;
    logic [13:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    logic [13:0] checksum;
`endif

    logic [13:0] mem [64];
    assign mem_data_in = mem[mem_addr];

    always #5 clk = ~clk;

    mem_stream_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(14)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .mem_addr     (mem_addr),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    int total = 0;
    int bad = 0;

    logic [13:0] got [$];
    int          done_cnt, done_c, first_c, last_c, stall_bad, ahead_bad;
    logic [13:0] cks_at_done;
    logic        rseq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] exp_word(input int base, input int i);
        return 14'(32'h100 + ((base + i) % 64));
    endfunction

    // Runs one command, logging transfers and protocol observations per cycle.
    task automatic run_cmd(input int base, input int len, input int mode, input bit poke);
        logic        prev_stall;
        logic [13:0] prev_data;
        int          d;
        got.delete();
        done_cnt = 0; done_c = -1; first_c = -1; last_c = -1;
        stall_bad = 0; ahead_bad = 0; cks_at_done = '0;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        start = 1'b1; base_addr = 6'(base); length = 7'(len); out_ready = 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            start = poke && (c == 3);
            if (poke) begin
                base_addr = 6'd40;
                length    = 7'd1;
            end
            if (out_valid && first_c < 0) first_c = c;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_bad++;
            if (done) begin
                done_cnt++;
                done_c = c;
`ifdef MEM_STREAM_READER_CHECKSUM_EN
                cks_at_done = checksum;
`endif
            end
            if (c >= 2 && got.size() < len) begin
                d = int'(6'(mem_addr - 6'(base) - 6'(got.size()))) + 1;
                if (d > 2) ahead_bad++;
            end
            out_ready = (mode == 0) ? 1'b1 : rseq[(c - 1) % 6];
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                last_c = c;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done_c > 0 && c == done_c + 1) break;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_words(input string tag, input int base, input int len);
        chk({tag, "_count"}, 32'(got.size()), 32'(len));
        for (int i = 0; i < got.size() && i < len; i++)
            chk($sformatf("%s_word%0d", tag, i), 32'(got[i]), 32'(exp_word(base, i)));
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 14'(32'h100 + k);

        // Reset values
        #1 n_rst = 1'b0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_write_en", 32'(mem_write_en), 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Full-rate stream of 4 words
        run_cmd(5, 4, 0, 1'b0);
        check_words("t1", 5, 4);
        chk("t1_first_valid_cycle", 32'(first_c), 32'd3);
        chk("t1_last_xfer_cycle", 32'(last_c), 32'd6);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_done_cycle", 32'(done_c), 32'(last_c + 1));
        chk("t1_ahead", 32'(ahead_bad), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_done_after", 32'(done), 32'd0);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        chk("t1_checksum", 32'(cks_at_done), 32'h41A);
`endif

        // Backpressure plus an ignored start while busy
        run_cmd(5, 4, 1, 1'b1);
        check_words("t2", 5, 4);
        chk("t2_stall_stable", 32'(stall_bad), 32'd0);
        chk("t2_ahead", 32'(ahead_bad), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt), 32'd1);
        chk("t2_done_cycle", 32'(done_c), 32'(last_c + 1));
        chk("t2_busy_after", 32'(busy), 32'd0);

        // Address wrap
        run_cmd(62, 4, 0, 1'b0);
        check_words("t3", 62, 4);
        chk("t3_done_cnt", 32'(done_cnt), 32'd1);

        // Zero-length command
        run_cmd(7, 0, 0, 1'b0);
        chk("t4_count", 32'(got.size()), 32'd0);
        chk("t4_no_valid", 32'(first_c), 32'hFFFF_FFFF);
        chk("t4_done_cycle", 32'(done_c), 32'd1);
        chk("t4_done_cnt", 32'(done_cnt), 32'd1);
`ifdef MEM_STREAM_READER_CHECKSUM_EN
        chk("t4_checksum", 32'(cks_at_done), 32'd0);
`endif

        // Whole memory
        run_cmd(0, 64, 0, 1'b0);
        check_words("t5", 0, 64);
        chk("t5_last_xfer_cycle", 32'(last_c), 32'd66);
        chk("t5_done_cycle", 32'(done_c), 32'd67);

        // Reset mid-stream with the FIFO backed up
        @(negedge clk);
        start = 1'b1; base_addr = 6'd20; length = 7'd10; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        chk("t6_pre_busy", 32'(busy), 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        chk("t6_rst_addr", 32'(mem_addr), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        n_rst = 1'b1;
        out_ready = 1'b1;
        run_cmd(10, 3, 0, 1'b0);
        check_words("t6_after", 10, 3);
        chk("t6_after_done_cnt", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
